alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  instruction/operands present this cycle.
REQ-004 in_ready  output  1  block accepts input when in_valid & in_ready.
REQ-005 instr  input  32  MIPS instruction word.
REQ-006 rs_data  input  32  GPR[rs] value.
REQ-007 rt_data  input  32  GPR[rt] value.
REQ-008 out_valid  output  1  issued ALU op present.
REQ-009 out_ready  input  1  ALU side consumes when out_valid & out_ready.
REQ-010 DataA  output  32  ALU operand A.
REQ-011 DataB  output  32  ALU operand B.
REQ-012 ALUFun  output  6  ALU function; [5:4] 00 add/sub, 01 logic, 10 shift, 11 compare.
REQ-013 Sign  output  1  1 = signed arithmetic/compare.
REQ-014 illegal  output  1  instruction not decodable.

Function
REQ-015 ALUFun codes: ADD 000001, SUB 000000, AND 011100, OR 011101, XOR 011110, NOR 011111, SLL 100000, SRL 100001, SRA 100010, EQ 110000, NE 110010, LTZ 110100, GTZ 110110, LEZ 111000, LT 111010.
REQ-016 R-type (op 0): add/addu->ADD, sub/subu->SUB, and/or/xor/nor, slt/sltu->LT; A=rs_data, B=rt_data.
REQ-017 sll/srl/sra: A={27'b0,instr[10:6]}, B=rt_data.
REQ-018 addi/addiu->ADD, slti/sltiu->LT: B=sign-extended imm; andi/ori/xori: B=zero-extended imm; A=rs_data.
REQ-019 lui: ALUFun=SLL, A=32'd16, B={16'b0,imm}.
REQ-020 beq->EQ, bne->NE: A=rs_data, B=rt_data; blez->LEZ, bgtz->GTZ, bltz (op 1, rt 0)->LTZ: A=rs_data, B=0.
REQ-021 Sign=1 for add, sub, slt, addi, slti, all branches; Sign=0 otherwise.
REQ-022 Any other encoding: illegal=1, ALUFun=ADD, A=B=0, Sign=0; still issued as a normal entry.
REQ-023 Decode registered: accepted input appears on outputs no earlier than next cycle (latency 1 when output empty).
REQ-024 Two-entry elastic buffer: main register drives outputs, skid register holds one extra entry.
REQ-025 in_ready = skid register empty; registered, no combinational path from out_ready.
REQ-026 Accept with main empty (or main draining this cycle and skid empty): load main.
REQ-027 Accept while main held (out_valid & ~out_ready): load skid.
REQ-028 Main drains with skid full: skid moves to main, in_ready rises next cycle.
REQ-029 Order strictly preserved; no entry dropped or duplicated; outputs stable while out_valid & ~out_ready.
REQ-030 Simultaneous accept and drain with one entry held: sustained 1 op/cycle throughput.

Reset
REQ-031 reset low: out_valid=0, in_ready=0 while asserted, both entries empty, DataA=DataB=0, ALUFun=0, Sign=0, illegal=0.
REQ-032 in_ready=1 on first clock edge after reset deasserts; in-flight entries discarded on reset mid-operation.

Configuration
REQ-033 VAR_SHIFT_EN defined: sllv/srlv/srav (funct 000100/000110/000111) decode to SLL/SRL/SRA with A=rs_data, B=rt_data.
REQ-034 VAR_SHIFT_EN undefined: those functs set illegal=1 per REQ-022.

Verification
REQ-035 addi $t,$s,-1 (0x2230FFFF), rs_data=5, out_ready=1 -> next cycle out_valid=1, ALUFun=000001, A=5, B=0xFFFFFFFF, Sign=1.
REQ-036 lui imm=0x1234 -> ALUFun=100000, A=16, B=0x00001234, illegal=0.
REQ-037 out_ready=0, three back-to-back inputs -> first two captured, in_ready=0 on third; release out_ready -> outputs in order, third accepted after skid frees.
REQ-038 bltz with rs_data=0x80000000 -> ALUFun=110100, B=0, Sign=1; instr=0xFC000000 -> illegal=1, A=B=0.
REQ-039 sllv (funct 000100) -> ALUFun=100000, A=rs_data when VAR_SHIFT_EN; illegal=1 without.
REQ-040 reset low with both entries full -> out_valid=0 immediately; after release in_ready=1 next edge, no stale output.

Source files
------------

// File: rtl/alu_issue_if.sv
// Issue-side handshake and ALU operand bus of alu_issue.
// master = the issue block itself, slave = its environment (fetch side plus ALU side).
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic [5:0]  ALUFun;
  logic        Sign;
  logic        illegal;

  modport master (
    input  in_valid, instr, rs_data, rt_data, out_ready,
    output in_ready, out_valid, DataA, DataB, ALUFun, Sign, illegal
  );

  modport slave (
    output in_valid, instr, rs_data, rt_data, out_ready,
    input  in_ready, out_valid, DataA, DataB, ALUFun, Sign, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: decodes a MIPS instruction into ALU operands/function and queues it in a main+skid buffer.
// Latency: 1 cycle from accept to out_valid when empty; sustains 1 op/cycle.
// Backpressure: in_ready is a register (skid empty); no combinational path from out_ready.
// Optional: define VAR_SHIFT_EN to decode sllv/srlv/srav; otherwise they decode as illegal.
module alu_issue (
  input logic         clk,
  input logic         reset,
  alu_issue_if.master bus
);
  localparam logic [5:0] F_ADD = 6'b000001;
  localparam logic [5:0] F_SUB = 6'b000000;
  localparam logic [5:0] F_AND = 6'b011100;
  localparam logic [5:0] F_OR  = 6'b011101;
  localparam logic [5:0] F_XOR = 6'b011110;
  localparam logic [5:0] F_NOR = 6'b011111;
  localparam logic [5:0] F_SLL = 6'b100000;
  localparam logic [5:0] F_SRL = 6'b100001;
  localparam logic [5:0] F_SRA = 6'b100010;
  localparam logic [5:0] F_EQ  = 6'b110000;
  localparam logic [5:0] F_NE  = 6'b110010;
  localparam logic [5:0] F_LTZ = 6'b110100;
  localparam logic [5:0] F_GTZ = 6'b110110;
  localparam logic [5:0] F_LEZ = 6'b111000;
  localparam logic [5:0] F_LT  = 6'b111010;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    logic        sign;
    logic        ill;
  } entry_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} occ_t;

  function automatic entry_t mk(logic [5:0] f_in, logic [31:0] a_in, logic [31:0] b_in,
                                logic s_in);
    mk = '{a: a_in, b: b_in, fun: f_in, sign: s_in, ill: 1'b0};
  endfunction

  // ---------------------------------------------------------------- decode
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt_f;
  logic [31:0] shamt_z;
  logic [31:0] imm_s;
  logic [31:0] imm_z;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        unused_fields;
  entry_t      dec;

  assign op            = bus.instr[31:26];
  assign funct         = bus.instr[5:0];
  assign rt_f          = bus.instr[20:16];
  assign shamt_z       = {27'd0, bus.instr[10:6]};
  assign imm_s         = {{16{bus.instr[15]}}, bus.instr[15:0]};
  assign imm_z         = {16'd0, bus.instr[15:0]};
  assign rs            = bus.rs_data;
  assign rt            = bus.rt_data;
  // Register-number fields are resolved upstream; only their values arrive here.
  assign unused_fields = ^{bus.instr[25:21], bus.instr[15:11]};

  always_comb begin
    dec = '{a: 32'd0, b: 32'd0, fun: F_ADD, sign: 1'b0, ill: 1'b1};
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000: dec = mk(F_ADD, rs, rt, 1'b1);
          6'b100001: dec = mk(F_ADD, rs, rt, 1'b0);
          6'b100010: dec = mk(F_SUB, rs, rt, 1'b1);
          6'b100011: dec = mk(F_SUB, rs, rt, 1'b0);
          6'b100100: dec = mk(F_AND, rs, rt, 1'b0);
          6'b100101: dec = mk(F_OR,  rs, rt, 1'b0);
          6'b100110: dec = mk(F_XOR, rs, rt, 1'b0);
          6'b100111: dec = mk(F_NOR, rs, rt, 1'b0);
          6'b101010: dec = mk(F_LT,  rs, rt, 1'b1);
          6'b101011: dec = mk(F_LT,  rs, rt, 1'b0);
          6'b000000: dec = mk(F_SLL, shamt_z, rt, 1'b0);
          6'b000010: dec = mk(F_SRL, shamt_z, rt, 1'b0);
          6'b000011: dec = mk(F_SRA, shamt_z, rt, 1'b0);
`ifdef VAR_SHIFT_EN
          6'b000100: dec = mk(F_SLL, rs, rt, 1'b0);
          6'b000110: dec = mk(F_SRL, rs, rt, 1'b0);
          6'b000111: dec = mk(F_SRA, rs, rt, 1'b0);
`endif
          default: ;
        endcase
      end
      // Only bltz (rt field 0) of the REGIMM group is handled.
      6'b000001: if (rt_f == 5'd0) dec = mk(F_LTZ, rs, 32'd0, 1'b1);
      6'b000100: dec = mk(F_EQ,  rs, rt, 1'b1);
      6'b000101: dec = mk(F_NE,  rs, rt, 1'b1);
      6'b000110: dec = mk(F_LEZ, rs, 32'd0, 1'b1);
      6'b000111: dec = mk(F_GTZ, rs, 32'd0, 1'b1);
      6'b001000: dec = mk(F_ADD, rs, imm_s, 1'b1);
      6'b001001: dec = mk(F_ADD, rs, imm_s, 1'b0);
      6'b001010: dec = mk(F_LT,  rs, imm_s, 1'b1);
      6'b001011: dec = mk(F_LT,  rs, imm_s, 1'b0);
      6'b001100: dec = mk(F_AND, rs, imm_z, 1'b0);
      6'b001101: dec = mk(F_OR,  rs, imm_z, 1'b0);
      6'b001110: dec = mk(F_XOR, rs, imm_z, 1'b0);
      // lui is an imm << 16 through the shifter.
      6'b001111: dec = mk(F_SLL, 32'd16, imm_z, 1'b0);
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- elastic buffer
  occ_t   state;
  occ_t   state_nxt;
  entry_t main_q;
  entry_t skid_q;
  logic   rdy_q;
  logic   accept;
  logic   drain;
  logic   load_main;
  logic   load_skid;
  logic   move_skid;

  assign accept = bus.in_valid & rdy_q;
  assign drain  = (state != S_EMPTY) & bus.out_ready;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      S_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = S_TWO;
        end else if (drain) begin
          state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        // rdy_q is low here, so no new entry can arrive alongside the move.
        if (drain) begin
          move_skid = 1'b1;
          state_nxt = S_ONE;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_EMPTY;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt != S_TWO);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= dec;
      end else if (move_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec;
      end
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (state != S_EMPTY);
  assign bus.DataA     = main_q.a;
  assign bus.DataB     = main_q.b;
  assign bus.ALUFun    = main_q.fun;
  assign bus.Sign      = main_q.sign;
  assign bus.illegal   = main_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: fixed decode vectors, hand-written backpressure/reset sequences,
// then random traffic against a queue-based reference model.
module tb_alu_issue;
  localparam logic [5:0] F_ADD = 6'b000001;
  localparam logic [5:0] F_SUB = 6'b000000;
  localparam logic [5:0] F_AND = 6'b011100;
  localparam logic [5:0] F_OR  = 6'b011101;
  localparam logic [5:0] F_XOR = 6'b011110;
  localparam logic [5:0] F_NOR = 6'b011111;
  localparam logic [5:0] F_SLL = 6'b100000;
  localparam logic [5:0] F_SRL = 6'b100001;
  localparam logic [5:0] F_SRA = 6'b100010;
  localparam logic [5:0] F_EQ  = 6'b110000;
  localparam logic [5:0] F_NE  = 6'b110010;
  localparam logic [5:0] F_LTZ = 6'b110100;
  localparam logic [5:0] F_GTZ = 6'b110110;
  localparam logic [5:0] F_LEZ = 6'b111000;
  localparam logic [5:0] F_LT  = 6'b111010;

  typedef struct packed {
    logic [5:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic        ill;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    exp_t        exp;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if ifc ();
  alu_issue u_dut (.clk(clk), .reset(reset), .bus(ifc));

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  vec_t vt[$];
  logic [5:0] fn_tab [0:17];
  logic [5:0] op_tab [0:13];

  function automatic exp_t E(logic [5:0] f, logic [31:0] va, logic [31:0] vb, logic s, logic il);
    E = '{fun: f, a: va, b: vb, sign: s, ill: il};
  endfunction

  function automatic exp_t got();
    got = {ifc.ALUFun, ifc.DataA, ifc.DataB, ifc.Sign, ifc.illegal};
  endfunction

  task automatic check_bit(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic check_ent(string name, exp_t act, exp_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got fun=%b a=%h b=%h s=%b ill=%b, required fun=%b a=%h b=%h s=%b ill=%b",
               name, act.fun, act.a, act.b, act.sign, act.ill,
               req.fun, req.a, req.b, req.sign, req.ill);
    end
  endtask

  // Reference decode: mnemonic rules straight from the instruction-set table.
  function automatic exp_t model(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
    logic [5:0]  op = ins[31:26];
    logic [5:0]  fn = ins[5:0];
    logic [31:0] se = {{16{ins[15]}}, ins[15:0]};
    logic [31:0] ze = {16'd0, ins[15:0]};
    logic [31:0] sh = {27'd0, ins[10:6]};
    logic        unused_bits = ^{ins[25:21], ins[15:11]};
    exp_t        r = E(F_ADD, 32'd0, 32'd0, 1'b0, 1'b1);
    if (op == 6'd0) begin
      if      (fn == 6'h20) r = E(F_ADD, rs, rt, 1'b1, 1'b0);
      else if (fn == 6'h21) r = E(F_ADD, rs, rt, 1'b0, 1'b0);
      else if (fn == 6'h22) r = E(F_SUB, rs, rt, 1'b1, 1'b0);
      else if (fn == 6'h23) r = E(F_SUB, rs, rt, 1'b0, 1'b0);
      else if (fn == 6'h24) r = E(F_AND, rs, rt, 1'b0, 1'b0);
      else if (fn == 6'h25) r = E(F_OR,  rs, rt, 1'b0, 1'b0);
      else if (fn == 6'h26) r = E(F_XOR, rs, rt, 1'b0, 1'b0);
      else if (fn == 6'h27) r = E(F_NOR, rs, rt, 1'b0, 1'b0);
      else if (fn == 6'h2A) r = E(F_LT,  rs, rt, 1'b1, 1'b0);
      else if (fn == 6'h2B) r = E(F_LT,  rs, rt, 1'b0, 1'b0);
      else if (fn == 6'h00) r = E(F_SLL, sh, rt, 1'b0, 1'b0);
      else if (fn == 6'h02) r = E(F_SRL, sh, rt, 1'b0, 1'b0);
      else if (fn == 6'h03) r = E(F_SRA, sh, rt, 1'b0, 1'b0);
`ifdef VAR_SHIFT_EN
      else if (fn == 6'h04) r = E(F_SLL, rs, rt, 1'b0, 1'b0);
      else if (fn == 6'h06) r = E(F_SRL, rs, rt, 1'b0, 1'b0);
      else if (fn == 6'h07) r = E(F_SRA, rs, rt, 1'b0, 1'b0);
`endif
    end
    else if (op == 6'h01 && ins[20:16] == 5'd0) r = E(F_LTZ, rs, 32'd0, 1'b1, 1'b0);
    else if (op == 6'h04) r = E(F_EQ,  rs, rt, 1'b1, 1'b0);
    else if (op == 6'h05) r = E(F_NE,  rs, rt, 1'b1, 1'b0);
    else if (op == 6'h06) r = E(F_LEZ, rs, 32'd0, 1'b1, 1'b0);
    else if (op == 6'h07) r = E(F_GTZ, rs, 32'd0, 1'b1, 1'b0);
    else if (op == 6'h08) r = E(F_ADD, rs, se, 1'b1, 1'b0);
    else if (op == 6'h09) r = E(F_ADD, rs, se, 1'b0, 1'b0);
    else if (op == 6'h0A) r = E(F_LT,  rs, se, 1'b1, 1'b0);
    else if (op == 6'h0B) r = E(F_LT,  rs, se, 1'b0, 1'b0);
    else if (op == 6'h0C) r = E(F_AND, rs, ze, 1'b0, 1'b0);
    else if (op == 6'h0D) r = E(F_OR,  rs, ze, 1'b0, 1'b0);
    else if (op == 6'h0E) r = E(F_XOR, rs, ze, 1'b0, 1'b0);
    else if (op == 6'h0F) r = E(F_SLL, 32'd16, ze, 1'b0, 1'b0);
    if (unused_bits === 1'bz) r.ill = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom();
    int          k = $urandom_range(0, 3);
    case (k)
      0:       return {6'd0, r[25:6], fn_tab[$urandom_range(0, 17)]};
      1:       return {op_tab[$urandom_range(0, 13)], r[25:0]};
      2:       return {6'b000001, r[25:21], 5'd0, r[15:0]};
      default: return r;
    endcase
  endfunction

  task automatic add_vec(string n, logic [31:0] ins, logic [31:0] rs, logic [31:0] rt, exp_t e);
    vec_t v;
    v.name = n; v.instr = ins; v.rs = rs; v.rt = rt; v.exp = e;
    vt.push_back(v);
  endtask

  task automatic drive(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
    ifc.in_valid = 1'b1;
    ifc.instr    = ins;
    ifc.rs_data  = rs;
    ifc.rt_data  = rt;
  endtask

  // Reset is low on entry; release it mid-cycle and check the first edge after.
  task automatic release_reset(string tag);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 check_bit({tag, ".rdy_before_edge"}, ifc.in_ready, 1'b0);
    @(negedge clk);
    check_bit({tag, ".rdy_after_edge"}, ifc.in_ready, 1'b1);
    check_bit({tag, ".vld_after_edge"}, ifc.out_valid, 1'b0);
  endtask

  // One scoreboarded cycle: inputs set at negedge, handshakes resolved by the model queue.
  task automatic sb_cycle(logic v, logic r);
    logic acc;
    logic drn;
    @(negedge clk);
    ifc.in_valid  = v;
    ifc.out_ready = r;
    ifc.instr     = rnd_instr();
    ifc.rs_data   = $urandom();
    ifc.rt_data   = $urandom();
    check_bit("rnd.in_ready", ifc.in_ready, q.size() < 2);
    check_bit("rnd.out_valid", ifc.out_valid, q.size() != 0);
    if (q.size() != 0) check_ent("rnd.data", got(), q[0]);
    drn = (q.size() != 0) && r;
    acc = v && (q.size() < 2);
    if (drn) void'(q.pop_front());
    if (acc) q.push_back(model(ifc.instr, ifc.rs_data, ifc.rt_data));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e1, e2, e3;
    fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
               6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h2C};
    op_tab = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A,
               6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h02, 6'h23};

    add_vec("addi_m1",   32'h2230FFFF, 32'd5, 32'd0, E(F_ADD, 32'd5, 32'hFFFFFFFF, 1'b1, 1'b0));
    add_vec("lui",       32'h3C011234, 32'hDEAD, 32'hBEEF, E(F_SLL, 32'd16, 32'h00001234, 1'b0, 1'b0));
    add_vec("bltz",      32'h04400005, 32'h80000000, 32'h77, E(F_LTZ, 32'h80000000, 32'd0, 1'b1, 1'b0));
    add_vec("bad_op",    32'hFC000000, 32'd7, 32'd9, E(F_ADD, 32'd0, 32'd0, 1'b0, 1'b1));
`ifdef VAR_SHIFT_EN
    add_vec("sllv",      32'h00642804, 32'hA, 32'h1234, E(F_SLL, 32'hA, 32'h1234, 1'b0, 1'b0));
`else
    add_vec("sllv",      32'h00642804, 32'hA, 32'h1234, E(F_ADD, 32'd0, 32'd0, 1'b0, 1'b1));
`endif
    add_vec("add",       32'h00642820, 32'd7, 32'hFFFFFFFE, E(F_ADD, 32'd7, 32'hFFFFFFFE, 1'b1, 1'b0));
    add_vec("subu",      32'h00642823, 32'd1, 32'd2, E(F_SUB, 32'd1, 32'd2, 1'b0, 1'b0));
    add_vec("nor",       32'h00642827, 32'h0F0F, 32'hF0F0, E(F_NOR, 32'h0F0F, 32'hF0F0, 1'b0, 1'b0));
    add_vec("slt",       32'h0064282A, 32'd3, 32'd4, E(F_LT, 32'd3, 32'd4, 1'b1, 1'b0));
    add_vec("sltu",      32'h0064282B, 32'd3, 32'd4, E(F_LT, 32'd3, 32'd4, 1'b0, 1'b0));
    add_vec("sra31",     32'h00042FC3, 32'h55, 32'h80000000, E(F_SRA, 32'd31, 32'h80000000, 1'b0, 1'b0));
    add_vec("andi_zext", 32'h3062FFFF, 32'h12345678, 32'd0, E(F_AND, 32'h12345678, 32'h0000FFFF, 1'b0, 1'b0));
    add_vec("beq",       32'h10640010, 32'd11, 32'd12, E(F_EQ, 32'd11, 32'd12, 1'b1, 1'b0));
    add_vec("bgtz",      32'h1C600003, 32'd11, 32'd12, E(F_GTZ, 32'd11, 32'd0, 1'b1, 1'b0));
    add_vec("bgez_bad",  32'h04610003, 32'd11, 32'd12, E(F_ADD, 32'd0, 32'd0, 1'b0, 1'b1));
    add_vec("sltiu",     32'h2C628000, 32'd9, 32'd0, E(F_LT, 32'd9, 32'hFFFF8000, 1'b0, 1'b0));
    add_vec("xori",      32'h38628000, 32'd9, 32'd0, E(F_XOR, 32'd9, 32'h00008000, 1'b0, 1'b0));

    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    ifc.instr     = 32'd0;
    ifc.rs_data   = 32'd0;
    ifc.rt_data   = 32'd0;

    // Power-on reset.
    #1 reset = 1'b0;
    #1;
    check_bit("por.out_valid", ifc.out_valid, 1'b0);
    check_bit("por.in_ready", ifc.in_ready, 1'b0);
    check_ent("por.outputs", got(), E(6'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    release_reset("por");

    // Decode table, one instruction at a time with the ALU side always ready.
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].instr, vt[i].rs, vt[i].rt);
      ifc.out_ready = 1'b1;
      @(negedge clk);
      ifc.in_valid = 1'b0;
      check_bit({vt[i].name, ".vld"}, ifc.out_valid, 1'b1);
      check_ent(vt[i].name, got(), vt[i].exp);
    end

    // Backpressure: three back-to-back inputs against a stalled ALU side.
    e1 = E(F_OR, 32'd0, 32'd1, 1'b0, 1'b0);
    e2 = E(F_OR, 32'd0, 32'd2, 1'b0, 1'b0);
    e3 = E(F_OR, 32'd0, 32'd3, 1'b0, 1'b0);
    @(negedge clk);
    ifc.out_ready = 1'b0;
    check_bit("bp.empty_before", ifc.out_valid, 1'b0);
    drive(32'h34010001, 32'd0, 32'd0);
    check_bit("bp.rdy_first", ifc.in_ready, 1'b1);
    @(negedge clk);
    drive(32'h34010002, 32'd0, 32'd0);
    check_bit("bp.rdy_second", ifc.in_ready, 1'b1);
    @(negedge clk);
    drive(32'h34010003, 32'd0, 32'd0);
    check_bit("bp.rdy_third", ifc.in_ready, 1'b0);
    check_ent("bp.head", got(), e1);
    @(negedge clk);
    check_ent("bp.head_stable", got(), e1);
    check_bit("bp.rdy_still_low", ifc.in_ready, 1'b0);
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check_ent("bp.second_out", got(), e2);
    check_bit("bp.rdy_reopened", ifc.in_ready, 1'b1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    check_bit("bp.third_vld", ifc.out_valid, 1'b1);
    check_ent("bp.third_out", got(), e3);
    @(negedge clk);
    check_bit("bp.drained", ifc.out_valid, 1'b0);

    // Reset while both entries are full.
    ifc.out_ready = 1'b0;
    drive(32'h34010004, 32'd0, 32'd0);
    @(negedge clk);
    drive(32'h34010005, 32'd0, 32'd0);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    check_bit("full.rdy", ifc.in_ready, 1'b0);
    check_bit("full.vld", ifc.out_valid, 1'b1);
    #2 reset = 1'b0;
    #1;
    check_bit("mid_rst.out_valid", ifc.out_valid, 1'b0);
    check_bit("mid_rst.in_ready", ifc.in_ready, 1'b0);
    check_ent("mid_rst.outputs", got(), E(6'd0, 32'd0, 32'd0, 1'b0, 1'b0));
    release_reset("mid_rst");
    ifc.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_bit("mid_rst.no_stale", ifc.out_valid, 1'b0);
    end

    // Streaming at full rate, then random traffic, then drain.
    q.delete();
    repeat (20) sb_cycle(1'b1, 1'b1);
    for (int c = 0; c < 1500; c++) begin
      sb_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
    end
    repeat (4) sb_cycle(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
